// File: rtl/vend_coin_if.sv
// Coin-scheduler signal bundle: coin events and machine status in, spaced coin pulses and stats out.
interface vend_coin_if #(parameter int CNT_W = 8);
    logic             five_in;
    logic             ten_in;
    logic             vm_done;
    logic             vm_change;
    logic             vm_five;
    logic             vm_ten;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] sales;
    logic [CNT_W-1:0] changes;

    modport master (
        output five_in, ten_in, vm_done, vm_change,
        input  vm_five, vm_ten, busy, overflow, sales, changes
    );

    modport slave (
        input  five_in, ten_in, vm_done, vm_change,
        output vm_five, vm_ten, busy, overflow, sales, changes
    );
endinterface

// File: rtl/vend_coin_scheduler.sv
// Queues coin events and replays them to the vending FSM as spaced single-cycle pulses, holding off
// while a dispense is in progress. Latency 2 cycles coin-to-pulse; full FIFO drops coins (sticky flag).
module vend_coin_scheduler #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    vend_coin_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t           state;
    logic [GW-1:0]    gap_cnt;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             five_q;
    logic             ten_q;
    logic             ovf_q;
    logic             done_q;
    logic             change_q;
    logic [CNT_W-1:0] sales_q;
    logic [CNT_W-1:0] changes_q;

    logic [CW-1:0] free;
    logic          push_five;
    logic          push_ten;
    logic          drop;
    logic          pop;
    logic          head;

    always_comb begin
        free      = CW'(DEPTH) - count;
        push_five = bus.five_in && (free != '0);
        push_ten  = bus.ten_in && (push_five ? (free >= CW'(2)) : (free != '0));
        drop      = (bus.five_in && !push_five) || (bus.ten_in && !push_ten);
        head      = mem[rd_ptr];
        // The last gap cycle doubles as the issue decision so pulses land exactly 1+GAP apart.
        pop       = !bus.vm_done && (count != '0) &&
                    ((state == S_IDLE) || ((state == S_GAP) && (gap_cnt == '0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            mem       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            five_q    <= 1'b0;
            ten_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            change_q  <= 1'b0;
            sales_q   <= '0;
            changes_q <= '0;
        end else begin
            five_q <= 1'b0;
            ten_q  <= 1'b0;
            if (pop) begin
                five_q <= !head;
                ten_q  <= head;
                rd_ptr <= rd_ptr + AW'(1);
                state  <= S_ISSUE;
            end else begin
                case (state)
                    S_IDLE:  state <= S_IDLE;
                    S_ISSUE: begin
                        gap_cnt <= GW'(GAP - 1);
                        state   <= S_GAP;
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) state <= S_IDLE;
                        else               gap_cnt <= gap_cnt - GW'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end

            // Five always takes the first free slot when both coins arrive together.
            if (push_five) mem[wr_ptr] <= 1'b0;
            if (push_ten)  mem[push_five ? wr_ptr + AW'(1) : wr_ptr] <= 1'b1;
            wr_ptr <= wr_ptr + AW'(push_five) + AW'(push_ten);
            count  <= count + CW'(push_five) + CW'(push_ten) - CW'(pop);

            if (drop) ovf_q <= 1'b1;

            done_q   <= bus.vm_done;
            change_q <= bus.vm_change;
            if (bus.vm_done && !done_q)     sales_q   <= sales_q + CNT_W'(1);
            if (bus.vm_change && !change_q) changes_q <= changes_q + CNT_W'(1);
        end
    end

    assign bus.vm_five  = five_q;
    assign bus.vm_ten   = ten_q;
    assign bus.overflow = ovf_q;
    assign bus.sales    = sales_q;
    assign bus.changes  = changes_q;
    assign bus.busy     = (count != '0) || (state != S_IDLE);
endmodule

// File: tb/tb_vend_coin_scheduler.sv
// Bench for vend_coin_scheduler: queue-and-timing reference model feeding a pulse scoreboard.
module tb_vend_coin_scheduler;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_coin_if #(.CNT_W(CNT_W)) bus ();

    vend_coin_scheduler #(.DEPTH(DEPTH), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit ten;
        int cyc;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    exp_t expq[$];

    // Reference model: coin queue plus the cycle of the most recent issue decision.
    bit             mq[$];
    bit             have_dec;
    int             last_dec;
    bit             ovf_m;
    bit [CNT_W-1:0] sales_m;
    bit [CNT_W-1:0] chg_m;
    bit             done_p;
    bit             chg_p;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest predicted one in kind and cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_pulse: got none expected ten=%0d at cycle %0d", expq[0].ten, expq[0].cyc);
                void'(expq.pop_front());
            end
            if (bus.vm_five === 1'b1 || bus.vm_ten === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got five=%0b ten=%0b expected none (cycle %0d)",
                             bus.vm_five, bus.vm_ten, cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("pulse_excl", {31'd0, bus.vm_five & bus.vm_ten}, 32'd0);
                    check("pulse_kind", {31'd0, bus.vm_ten}, {31'd0, e.ten});
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic step(bit r, bit f, bit t, bit d, bit c);
        int  k;
        int  fr;
        bit  exp_busy;
        k = cyc;
        rst           = r;
        bus.five_in   = f;
        bus.ten_in    = t;
        bus.vm_done   = d;
        bus.vm_change = c;
        if (r) begin
            mq.delete();
            have_dec = 0;
            ovf_m    = 0;
            sales_m  = '0;
            chg_m    = '0;
            done_p   = 0;
            chg_p    = 0;
            for (int i = expq.size() - 1; i >= 0; i--)
                if (expq[i].cyc > k) expq.delete(i);
        end else begin
            fr = DEPTH - mq.size();
            if (mq.size() > 0 && !d && (!have_dec || k >= last_dec + 1 + GAP)) begin
                exp_t e;
                e.ten = mq.pop_front();
                e.cyc = k + 1;
                expq.push_back(e);
                last_dec = k;
                have_dec = 1;
            end
            if (f) begin
                if (fr > 0) begin mq.push_back(1'b0); fr--; end
                else ovf_m = 1;
            end
            if (t) begin
                if (fr > 0) begin mq.push_back(1'b1); fr--; end
                else ovf_m = 1;
            end
            if (d && !done_p) sales_m++;
            if (c && !chg_p)  chg_m++;
            done_p = d;
            chg_p  = c;
        end
        @(posedge clk);
        #1;
        exp_busy = (mq.size() != 0) || (have_dec && (k + 1) <= last_dec + 1 + GAP);
        check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
        check("overflow", {31'd0, bus.overflow}, {31'd0, ovf_m});
        check("sales", {24'd0, bus.sales}, {24'd0, sales_m});
        check("changes", {24'd0, bus.changes}, {24'd0, chg_m});
    endtask

    task automatic idle(int n, bit d);
        for (int i = 0; i < n; i++) step(0, 0, 0, d, 0);
    endtask

    initial begin
        bit d;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        mon_en = 1'b1;

        // Single five coin: pulse two cycles later, then idle.
        step(0, 1, 0, 0, 0);
        idle(6, 0);
        check("idle_after_single", {31'd0, bus.busy}, 32'd0);

        // Five and ten together: both issued, five first, 1+GAP apart.
        step(0, 1, 1, 0, 0);
        idle(8, 0);

        // Four fives queued under hold-off, then released.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
        idle(4, 1);
        idle(16, 0);

        // Overflow: three queued, then both coins with one free slot.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        check("overflow_set", {31'd0, bus.overflow}, 32'd1);
        idle(3, 1);
        idle(16, 0);
        check("overflow_sticky", {31'd0, bus.overflow}, 32'd1);

        // Counter wrap: 256 done edges, 3 change edges.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 0, 1, (i < 3));
            step(0, 0, 0, 0, 0);
        end
        check("sales_wrap", {24'd0, bus.sales}, 32'd0);
        check("changes_three", {24'd0, bus.changes}, 32'd3);

        // Reset during GAP with two coins still queued.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_five", {31'd0, bus.vm_five}, 32'd0);
        check("rst_ten", {31'd0, bus.vm_ten}, 32'd0);
        idle(10, 0);

        // Randomised traffic with occasional hold-off, change and reset.
        d = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) d = ~d;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 d,
                 ($urandom_range(0, 4) == 0));
        end
        idle(40, 0);
        @(negedge clk);
        check("drained", expq.size(), 32'd0);
        check("final_busy", {31'd0, bus.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
